// File: rtl/programmable_sequence_detector_pkg.sv
// seq_det_pkg: shared state encoding and width helpers for the programmable sequence detector
package seq_det_pkg;
  localparam logic [1:0] S_UNCFG = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_RUN = 2'd2;
  typedef enum logic [1:0] {UNCFG = S_UNCFG, FILL = S_FILL, RUN = S_RUN} seq_det_state_t;
  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction
  localparam int MAX_LEN_DEF = 8;
  localparam int LEN_W = len_w(MAX_LEN_DEF);
endpackage

// File: rtl/programmable_sequence_detector_if.sv
// programmable_sequence_detector_if: serial stream, configuration and result signals of the detector
interface programmable_sequence_detector_if #(
  parameter int MAX_LEN = seq_det_pkg::MAX_LEN_DEF,
  parameter int CNT_W = 8
);
  import seq_det_pkg::*;
  localparam int LW = len_w(MAX_LEN);
  logic a;
  logic a_vld;
  logic cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LW-1:0] cfg_len;
  logic cfg_overlap;
  logic detected;
  logic cfg_err;
  logic [CNT_W-1:0] match_count;
  modport master (
    output a, a_vld, cfg_load, cfg_pattern, cfg_len, cfg_overlap,
    input detected, cfg_err, match_count
  );
  modport slave (
    input a, a_vld, cfg_load, cfg_pattern, cfg_len, cfg_overlap,
    output detected, cfg_err, match_count
  );
endinterface

// File: rtl/programmable_sequence_detector_sat_counter.sv
// sat_counter: W-bit up counter that holds at all-ones instead of wrapping
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk)
    cnt_q <= rst ? '0 : (inc && !(&cnt_q)) ? cnt_q + W'(1) : cnt_q;
  assign cnt = cnt_q;
endmodule

// File: rtl/programmable_sequence_detector.sv
// programmable_sequence_detector: run-time programmable serial pattern detector with registered match pulse
// Optional saturating match counter built when SEQ_DET_MATCH_COUNT_EN is defined.
module programmable_sequence_detector
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst,
  programmable_sequence_detector_if.slave bus
);
  localparam int LW = len_w(MAX_LEN);
  seq_det_state_t state_q, state_d;
  logic [MAX_LEN-2:0] hist_q, hist_d;
  logic [MAX_LEN-1:0] pat_q, pat_d, mask, shifted;
  logic [LW-1:0] fill_q, fill_d, len_q, len_d, fill_inc;
  logic ovl_q, ovl_d, det_q, err_q, cfg_ok, take, hit;
  always_comb begin
    for (int i = 0; i < MAX_LEN; i++) mask[i] = LW'(i) < len_q;
    cfg_ok = bus.cfg_len != '0 && bus.cfg_len <= LW'(MAX_LEN);
    shifted = {hist_q, bus.a};
    fill_inc = fill_q + LW'(1);
    take = bus.a_vld && !bus.cfg_load && state_q != UNCFG;
    hit = take && ((shifted ^ pat_q) & mask) == '0 && (state_q == RUN || fill_inc == len_q);
    state_d = state_q;
    hist_d = hist_q;
    fill_d = fill_q;
    pat_d = pat_q;
    len_d = len_q;
    ovl_d = ovl_q;
    if (bus.cfg_load && cfg_ok) begin
      state_d = FILL;
      hist_d = '0;
      fill_d = '0;
      pat_d = bus.cfg_pattern;
      len_d = bus.cfg_len;
      ovl_d = bus.cfg_overlap;
    end else if (hit && !ovl_q) begin
      state_d = FILL;
      hist_d = '0;
      fill_d = '0;
    end else if (take) begin
      // fill saturates at len once running; history keeps sliding
      hist_d = shifted[MAX_LEN-2:0];
      fill_d = state_q == FILL ? fill_inc : fill_q;
      state_d = (state_q == FILL && fill_inc == len_q) ? RUN : state_q;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= UNCFG;
      hist_q <= '0;
      fill_q <= '0;
      pat_q <= '0;
      len_q <= '0;
      ovl_q <= 1'b0;
      det_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      pat_q <= pat_d;
      len_q <= len_d;
      ovl_q <= ovl_d;
      det_q <= hit;
      err_q <= bus.cfg_load && !cfg_ok;
    end
  end
  assign bus.detected = det_q;
  assign bus.cfg_err = err_q;
`ifdef SEQ_DET_MATCH_COUNT_EN
  sat_counter #(.W(CNT_W)) u_cnt (
    .clk(clk),
    .rst(rst),
    .inc(hit),
    .cnt(bus.match_count)
  );
`else
  assign bus.match_count = {CNT_W{1'b0}};
`endif
endmodule

// File: doc/programmable_sequence_detector.md
# programmable_sequence_detector

- Run-time programmable serial bit-pattern detector: one pattern up to MAX_LEN bits, selectable overlapping or non-overlapping detection, input qualified by a valid strobe.
- Generalises the team's fixed-pattern FSM detectors (4-bit "1010", 6-bit "110011") so the pattern is a configuration value instead of hard-coded states.
- Sits on a serial input stream and drives a one-cycle detection pulse; an optional saturating match counter is available.

## Interface
Parameters:
- MAX_LEN, default 8: maximum pattern length in bits; must be ≥ 2.
- CNT_W, default 8: match counter width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- a  in  1  serial data bit.
- a_vld  in  1  `a` is sampled only when a_vld = 1.
- cfg_load  in  1  latch the cfg_* inputs this cycle.
- cfg_pattern  in  MAX_LEN  pattern bits; bit [cfg_len-1] is the first expected bit, bit [0] the last.
- cfg_len  in  $clog2(MAX_LEN+1)  pattern length.
- cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
- detected  out  1  one-cycle match pulse.
- cfg_err  out  1  one-cycle pulse when a load is rejected.
- match_count  out  CNT_W  saturating count of matches.

## Operation
FSM states: UNCFG, FILL, RUN.
- Reset: state = UNCFG. History, fill counter, detected, cfg_err and match_count all = 0. Stored pattern and length = 0.
- UNCFG:
  - a_vld is ignored.
  - A valid cfg_load goes to FILL.
- Valid load: 1 ≤ cfg_len ≤ MAX_LEN.
  - Stores pattern, length and overlap mode.
  - Clears history and fill counter; match_count is kept.
  - Next state = FILL.
- Invalid load (cfg_len = 0 or > MAX_LEN):
  - cfg_err pulses.
  - State and stored configuration are unchanged.
- FILL:
  - Each valid bit shifts into history (LSB = newest) and increments fill.
  - When fill reaches len, state = RUN.
  - The bit that makes fill = len is compared in the same cycle.
- RUN, on a valid bit: match when history[len-1:0] equals pattern[len-1:0], the new bit included.
- Overlapping match: state stays RUN.
- Non-overlapping match: history and fill are cleared, state = FILL.
- cfg_load and a_vld in the same cycle: the load wins and the bit is discarded.
- Cycles with a_vld = 0 leave history, fill and state unchanged. A gap never breaks a partial match.
- match_count increments on each match and saturates at 2^CNT_W − 1 (no wrap).
- rst in any state overrides everything, including a pending match.

## Timing
- detected and cfg_err are registered.
- detected is high for exactly the one cycle after the clk edge that sampled the final pattern bit, matching the latency of the existing FSM detectors.
- cfg_err is high for the one cycle after the rejected load.
- match_count updates on the same edge as detected.
- Minimum spacing between pulses:
  - Overlapping mode, len = 1: back-to-back pulses are possible.
  - Non-overlapping mode: at least len valid bits between matches.

## Configuration
- SEQ_DET_MATCH_COUNT_EN defined: the saturating counter is built and match_count behaves as above.
- Undefined: no counter logic is built and match_count is tied to 0. The port list is unchanged.

## Structure
- Package seq_det_pkg:
  - State enum seq_det_state_t {UNCFG, FILL, RUN}.
  - Localparam LEN_W = $clog2(MAX_LEN+1) as a function of MAX_LEN.
- Sub-module sat_counter (parameter W, inputs clk / rst / inc, output cnt).
  - Instantiated only under SEQ_DET_MATCH_COUNT_EN.

## Test plan
- Overlap match: load 6'b110011, len 6, overlap = 1. Stream 1100110011 with a_vld = 1 throughout → detected after bits 6 and 10; match_count = 2.
- Non-overlap: same load and stream with overlap = 0 → detected after bit 6 only; match_count = 1.
- Valid gaps: len 4, pattern 1010. Stream 1,0,(a_vld=0 ×3),1,0 → one pulse, one cycle after the last bit is sampled.
- Bad load: cfg_len = 0, then cfg_len = MAX_LEN+1 → two cfg_err pulses; the prior pattern keeps matching.
- Load collision: cfg_load and a_vld in the same cycle → the bit is dropped and fill = 0 afterwards. In UNCFG any stream gives no detection.
- Counter: CNT_W = 2 with 5 matches → match_count ends at 3. rst mid-FILL → all outputs 0 and state = UNCFG on the next cycle.
